// File: rtl/mem_ring_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ring_responder
//  Description : Ring-node responder that serves one memory transaction at a
//                time. It collects 64-byte write lines beat by beat from the
//                ring, writes them to backing memory and returns an ack. It
//                also services line reads from backing memory and returns the
//                four data beats on empty ring slots.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ring_responder (
  input  logic         clk,
  input  logic         rst,
  // ring slot currently at this node
  input  logic [2:0]   pkt_type_in,
  input  logic [4:0]   pkt_id_in,
  input  logic [35:0]  pkt_addr_in,
  input  logic [127:0] pkt_data_in,
  // slot replacement
  output logic         overwrite,
  output logic [2:0]   pkt_type_out,
  output logic [4:0]   pkt_id_out,
  output logic [35:0]  pkt_addr_out,
  output logic [127:0] pkt_data_out,
  // backing memory
  output logic         mem_req,
  output logic         mem_we,
  output logic [35:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic         mem_rvalid,
  input  logic [127:0] mem_rdata
);

  // Ring packet type encodings
  localparam logic [2:0] c_PKT_EMPTY   = 3'b000;
  localparam logic [2:0] c_PKT_WR_BEAT = 3'b001;
  localparam logic [2:0] c_PKT_RD_REQ  = 3'b011;
  localparam logic [2:0] c_PKT_WR_ACK  = 3'b101;
  localparam logic [2:0] c_PKT_RD_DATA = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_COLLECT = 3'd1,
    ST_WR_MEM     = 3'd2,
    ST_WR_ACK     = 3'd3,
    ST_RD_MEM     = 3'd4,
    ST_RD_RESP    = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  // Latched transaction context
  logic [4:0]    r_id;
  logic [29:0]   r_line;
  logic [3:0]    r_beat_mask;
  logic [127:0]  r_wr_buf   [4];
  logic [127:0]  r_resp_buf [4];

  // Memory-side issue counter: bits [1:0] are the beat, bit 2 marks that all
  // four read requests have been issued.
  logic [2:0]    r_issue_cnt;
  logic [1:0]    r_rcnt;
  logic [1:0]    r_send_cnt;

  // Decoded conditions
  logic          w_slot_empty;
  logic [1:0]    w_beat;
  logic          w_same_line;
  logic          w_rd_start;
  logic          w_wr_start;
  logic          w_wr_match;
  logic          w_capture;
  logic [3:0]    w_mask_next;
  logic          w_mem_req;
  logic          w_mem_fire;
  logic          w_rd_beat;
  logic          w_send;
  logic [1:0]    w_issue_beat;
  logic          w_unused;

  assign w_slot_empty = (pkt_type_in == c_PKT_EMPTY);
  assign w_beat       = pkt_addr_in[5:4];
  assign w_same_line  = (pkt_addr_in[35:6] == r_line);
  assign w_rd_start   = (r_state == ST_IDLE) && (pkt_type_in == c_PKT_RD_REQ);
  assign w_wr_start   = (r_state == ST_IDLE) && (pkt_type_in == c_PKT_WR_BEAT);
  assign w_wr_match   = (r_state == ST_WR_COLLECT) && (pkt_type_in == c_PKT_WR_BEAT) &&
                        (pkt_id_in == r_id) && w_same_line;
  assign w_capture    = w_wr_start || w_wr_match;
  // A new write starts with a fresh mask; later beats accumulate into it.
  assign w_mask_next  = w_wr_start ? (4'b0001 << w_beat) : (r_beat_mask | (4'b0001 << w_beat));
  assign w_issue_beat = r_issue_cnt[1:0];
  assign w_mem_req    = !rst && ((r_state == ST_WR_MEM) ||
                                 ((r_state == ST_RD_MEM) && !r_issue_cnt[2]));
  assign w_mem_fire   = w_mem_req && mem_ready;
  // Read data is only meaningful while waiting on our own read burst.
  assign w_rd_beat    = (r_state == ST_RD_MEM) && mem_rvalid;
  assign w_send       = (r_state == ST_RD_RESP) && w_slot_empty;

  // Low address bits below the beat index carry no information here.
  assign w_unused     = ^pkt_addr_in[3:0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and ring/memory output drive
  always_comb begin
    w_state_next = r_state;
    overwrite    = 1'b0;
    pkt_type_out = c_PKT_EMPTY;
    pkt_id_out   = 5'd0;
    pkt_addr_out = 36'd0;
    pkt_data_out = 128'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 36'd0;
    mem_wdata    = 128'd0;

    case (r_state)
      ST_IDLE: begin
        if (w_rd_start) begin
          w_state_next = ST_RD_MEM;
        end else if (w_wr_start) begin
          w_state_next = ST_WR_COLLECT;
        end
      end
      ST_WR_COLLECT: begin
        if (w_wr_match && (w_mask_next == 4'b1111)) begin
          w_state_next = ST_WR_MEM;
        end
      end
      ST_WR_MEM: begin
        if (w_mem_fire && (w_issue_beat == 2'd3)) begin
          w_state_next = ST_WR_ACK;
        end
      end
      ST_WR_ACK: begin
        if (w_slot_empty) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RD_MEM: begin
        if (w_rd_beat && (r_rcnt == 2'd3)) begin
          w_state_next = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (w_send && (r_send_cnt == 2'd3)) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Outputs are held at zero while reset is asserted, independent of state.
    if (!rst) begin
      mem_req = w_mem_req;
      case (r_state)
        ST_IDLE: begin
          // Consuming a slot means replacing it with an empty packet.
          overwrite = w_rd_start || w_wr_start;
        end
        ST_WR_COLLECT: begin
          overwrite = w_wr_match;
        end
        ST_WR_MEM: begin
          mem_we    = 1'b1;
          mem_addr  = {r_line, w_issue_beat, 4'b0000};
          mem_wdata = r_wr_buf[w_issue_beat];
        end
        ST_WR_ACK: begin
          if (w_slot_empty) begin
            overwrite    = 1'b1;
            pkt_type_out = c_PKT_WR_ACK;
            pkt_id_out   = r_id;
            pkt_addr_out = {r_line, 6'b000000};
          end
        end
        ST_RD_MEM: begin
          mem_addr = {r_line, w_issue_beat, 4'b0000};
        end
        ST_RD_RESP: begin
          if (w_send) begin
            overwrite    = 1'b1;
            pkt_type_out = c_PKT_RD_DATA;
            pkt_id_out   = r_id;
            pkt_addr_out = {r_line, r_send_cnt, 4'b0000};
            pkt_data_out = r_resp_buf[r_send_cnt];
          end
        end
        default: begin
          overwrite = 1'b0;
        end
      endcase
    end
  end

  // Transaction context, beat collection and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id        <= 5'd0;
      r_line      <= 30'd0;
      r_beat_mask <= 4'd0;
      r_issue_cnt <= 3'd0;
      r_rcnt      <= 2'd0;
      r_send_cnt  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_wr_buf[i]   <= 128'd0;
        r_resp_buf[i] <= 128'd0;
      end
    end else begin
      if (w_rd_start || w_wr_start) begin
        r_id   <= pkt_id_in;
        r_line <= pkt_addr_in[35:6];
      end

      // A repeated beat index simply overwrites the earlier beat data.
      if (w_capture) begin
        r_beat_mask      <= w_mask_next;
        r_wr_buf[w_beat] <= pkt_data_in;
      end else if (r_state == ST_IDLE) begin
        r_beat_mask <= 4'd0;
      end

      if (r_state == ST_IDLE) begin
        r_issue_cnt <= 3'd0;
      end else if (w_mem_fire) begin
        r_issue_cnt <= r_issue_cnt + 3'd1;
      end

      if (r_state == ST_IDLE) begin
        r_rcnt <= 2'd0;
      end else if (w_rd_beat) begin
        r_rcnt <= r_rcnt + 2'd1;
      end

      if (w_rd_beat) begin
        r_resp_buf[r_rcnt] <= mem_rdata;
      end

      if (r_state == ST_IDLE) begin
        r_send_cnt <= 2'd0;
      end else if (w_send) begin
        r_send_cnt <= r_send_cnt + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ring_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ring_responder
//  Description : Directed self-checking bench for mem_ring_responder with a
//                small backing-memory model (3-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ring_responder;

  logic         clk;
  logic         rst;
  logic [2:0]   pkt_type_in;
  logic [4:0]   pkt_id_in;
  logic [35:0]  pkt_addr_in;
  logic [127:0] pkt_data_in;
  logic         overwrite;
  logic [2:0]   pkt_type_out;
  logic [4:0]   pkt_id_out;
  logic [35:0]  pkt_addr_out;
  logic [127:0] pkt_data_out;
  logic         mem_req;
  logic         mem_we;
  logic [35:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_ring_responder dut (
    .clk          (clk),
    .rst          (rst),
    .pkt_type_in  (pkt_type_in),
    .pkt_id_in    (pkt_id_in),
    .pkt_addr_in  (pkt_addr_in),
    .pkt_data_in  (pkt_data_in),
    .overwrite    (overwrite),
    .pkt_type_out (pkt_type_out),
    .pkt_id_out   (pkt_id_out),
    .pkt_addr_out (pkt_addr_out),
    .pkt_data_out (pkt_data_out),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a fixed function of the beat address
  function automatic logic [127:0] mdata(input logic [35:0] a);
    return {a[31:0], ~a[31:0], a[31:0] ^ 32'hDEADBEEF, 28'h0, a[35:32]};
  endfunction

  // Backing-memory model: logs accepted requests, returns reads 3 cycles later
  logic         p0_v = 1'b0, p1_v = 1'b0, model_rvalid = 1'b0;
  logic [127:0] p0_d = '0, p1_d = '0, model_rdata = '0;
  logic         stray_rvalid = 1'b0;
  logic         log_we   [$];
  logic [35:0]  log_addr [$];
  logic [127:0] log_data [$];

  assign mem_rvalid = model_rvalid | stray_rvalid;
  assign mem_rdata  = stray_rvalid ? 128'hBAD0BAD0 : model_rdata;

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      log_we.push_back(mem_we);
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
    p0_v         <= mem_req && mem_ready && !mem_we;
    p0_d         <= mdata(mem_addr);
    p1_v         <= p0_v;
    p1_d         <= p0_d;
    model_rvalid <= p1_v;
    model_rdata  <= p1_d;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input logic [2:0] t, input logic [4:0] id, input logic [35:0] a,
                      input logic [127:0] d);
    pkt_type_in = t;
    pkt_id_in   = id;
    pkt_addr_in = a;
    pkt_data_in = d;
    #1;
  endtask

  task automatic log_clear();
    log_we.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  // Runs the ring while a read is in flight; foreign 110 packets occupy every
  // third slot. Stops once stop_after data packets have been observed.
  task automatic run_read(input logic [4:0] id, input logic [35:0] base,
                          input int stop_after, output int sent);
    sent = 0;
    for (int i = 0; i < 80 && sent < stop_after; i++) begin
      step();
      if (i % 3 == 1) slot(3'b110, 5'd9, 36'h0_0000_0040, 128'h55);
      else            slot(3'b000, 5'd0, 36'h0, 128'h0);
      if (pkt_type_in != 3'b000) begin
        chk("rd_busy_pass", overwrite, 1'b0);
      end else if (overwrite) begin
        chk("rd_type", pkt_type_out, 3'b110);
        chk("rd_id",   pkt_id_out, id);
        chk("rd_addr", pkt_addr_out, base + 36'(sent * 16));
        chk("rd_data", pkt_data_out, mdata(base + 36'(sent * 16)));
        sent++;
      end
    end
    chk("rd_count", sent, stop_after);
  endtask

  task automatic chk_rd_log(input logic [35:0] base);
    chk("rd_log_n", log_addr.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < log_addr.size()) begin
        chk("rd_log_we",   log_we[k], 1'b0);
        chk("rd_log_addr", log_addr[k], base + 36'(k * 16));
      end
    end
    log_clear();
  endtask

  initial begin
    int           sent;
    logic         acked;
    logic [35:0]  w_base;
    logic [127:0] exp_wd [4];

    // ---------------- reset ----------------
    rst = 1'b1;
    mem_ready = 1'b1;
    slot(3'b011, 5'd1, 36'h0_0000_0100, 128'h0);
    chk("rst_overwrite", overwrite, 1'b0);
    chk("rst_mem_req",   mem_req, 1'b0);
    chk("rst_mem_we",    mem_we, 1'b0);
    chk("rst_type_out",  pkt_type_out, 3'b000);
    step();
    step();
    rst = 1'b0;
    slot(3'b000, 5'd0, 36'h0, 128'h0);

    // ---------------- stray rvalid in IDLE ----------------
    stray_rvalid = 1'b1;
    #1;
    chk("stray_overwrite", overwrite, 1'b0);
    chk("stray_mem_req",   mem_req, 1'b0);
    step();
    step();
    stray_rvalid = 1'b0;
    #1;
    chk("stray_after_req", mem_req, 1'b0);
    log_clear();

    // ---------------- read id 5 ----------------
    step();
    slot(3'b011, 5'd5, 36'h1_2345_6780, 128'h0);
    chk("rd5_consume", overwrite, 1'b1);
    chk("rd5_consume_type", pkt_type_out, 3'b000);
    run_read(5'd5, 36'h1_2345_6780, 4, sent);
    step();
    slot(3'b000, 5'd0, 36'h0, 128'h0);
    chk("rd5_no_extra", overwrite, 1'b0);
    chk_rd_log(36'h1_2345_6780);

    // ---------------- write id 2, beats 3,1,(dup 1),0,2 ----------------
    w_base    = 36'h0_ABCD_EF40;
    exp_wd[0] = 128'h0000_0000_0000_0000_0000_0000_0000_D0D0;
    exp_wd[1] = 128'h1111_2222_3333_4444_5555_6666_7777_B1B1;
    exp_wd[2] = 128'h2222_0000_2222_0000_2222_0000_2222_D2D2;
    exp_wd[3] = 128'h3333_3333_3333_3333_3333_3333_3333_D3D3;
    step();
    slot(3'b001, 5'd2, w_base + 36'd48, exp_wd[3]);
    chk("wr_b3_consume", overwrite, 1'b1);
    chk("wr_b3_type",    pkt_type_out, 3'b000);
    step();
    slot(3'b001, 5'd2, w_base + 36'd16, 128'hA1A1);
    chk("wr_b1a_consume", overwrite, 1'b1);
    step();
    slot(3'b011, 5'd7, 36'h0_0000_1000, 128'h0);
    chk("busy_rd7_pass", overwrite, 1'b0);
    step();
    slot(3'b001, 5'd3, w_base, 128'hEE);
    chk("wr_other_id_pass", overwrite, 1'b0);
    step();
    slot(3'b001, 5'd2, w_base + 36'd64, 128'hEE);
    chk("wr_other_line_pass", overwrite, 1'b0);
    step();
    slot(3'b001, 5'd2, w_base + 36'd16, exp_wd[1]);
    chk("wr_b1b_consume", overwrite, 1'b1);
    chk("wr_no_mem_yet", mem_req, 1'b0);
    step();
    slot(3'b001, 5'd2, w_base, exp_wd[0]);
    chk("wr_b0_consume", overwrite, 1'b1);
    chk("wr_no_mem_3of4", mem_req, 1'b0);
    step();
    slot(3'b001, 5'd2, w_base + 36'd32, exp_wd[2]);
    chk("wr_b2_consume", overwrite, 1'b1);

    // memory writes with stalls, ring busy for 5 cycles, then ack
    acked = 1'b0;
    for (int i = 0; i < 30 && !acked; i++) begin
      step();
      mem_ready = !(i == 0 || i == 1 || i == 3);
      if (i < 5) slot(3'b101, 5'd9, 36'h0_0000_0200, 128'h77);
      else       slot(3'b000, 5'd0, 36'h0, 128'h0);
      if (pkt_type_in != 3'b000) chk("wr_busy_pass", overwrite, 1'b0);
      if (mem_req && !mem_ready) begin
        chk("wr_hold_we",   mem_we, 1'b1);
        chk("wr_hold_addr", mem_addr, w_base + 36'(log_addr.size() * 16));
      end
      if (overwrite) begin
        acked = 1'b1;
        chk("ack_after_writes", log_addr.size(), 4);
        chk("ack_type", pkt_type_out, 3'b101);
        chk("ack_id",   pkt_id_out, 5'd2);
        chk("ack_addr", pkt_addr_out, w_base);
        chk("ack_data", pkt_data_out, 128'h0);
      end
    end
    chk("ack_seen", acked, 1'b1);
    mem_ready = 1'b1;
    chk("wr_log_n", log_addr.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < log_addr.size()) begin
        chk("wr_log_we",   log_we[k], 1'b1);
        chk("wr_log_addr", log_addr[k], w_base + 36'(k * 16));
        chk("wr_log_data", log_data[k], exp_wd[k]);
      end
    end
    log_clear();
    step();
    slot(3'b000, 5'd0, 36'h0, 128'h0);
    chk("ack_once", overwrite, 1'b0);

    // ---------------- id 7 read on a later pass ----------------
    step();
    slot(3'b011, 5'd7, 36'h0_0000_1000, 128'h0);
    chk("rd7_consume", overwrite, 1'b1);
    chk("rd7_consume_type", pkt_type_out, 3'b000);
    run_read(5'd7, 36'h0_0000_1000, 4, sent);
    chk_rd_log(36'h0_0000_1000);

    // ---------------- reset during RD_RESP ----------------
    step();
    slot(3'b011, 5'd4, 36'h8_7654_3200, 128'h0);
    chk("rd4_consume", overwrite, 1'b1);
    run_read(5'd4, 36'h8_7654_3200, 2, sent);
    step();
    rst = 1'b1;
    slot(3'b000, 5'd0, 36'h0, 128'h0);
    chk("midrst_overwrite", overwrite, 1'b0);
    chk("midrst_type_out",  pkt_type_out, 3'b000);
    chk("midrst_id_out",    pkt_id_out, 5'd0);
    chk("midrst_addr_out",  pkt_addr_out, 36'h0);
    chk("midrst_data_out",  pkt_data_out, 128'h0);
    chk("midrst_mem_req",   mem_req, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      slot(3'b000, 5'd0, 36'h0, 128'h0);
      chk("postrst_silent", overwrite, 1'b0);
    end
    log_clear();

    // ---------------- fresh read after reset ----------------
    step();
    slot(3'b011, 5'd6, 36'h2_0000_0FC0, 128'h0);
    chk("rd6_consume", overwrite, 1'b1);
    run_read(5'd6, 36'h2_0000_0FC0, 4, sent);
    chk_rd_log(36'h2_0000_0FC0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_ring_responder.md
MEM_RING_RESPONDER -- requirements
Module: mem_ring_responder

Interface
REQ-001 SHALL have no parameters; the line is 64 B (4 beats of 128 bits), addresses are 36 bits, and beat index is addr[5:4].
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 pkt_type_in  in  3  type of the ring slot currently at this node: 000 empty, 001 write beat, 011 read request, 101 write ack, 110 read data.
REQ-005 pkt_id_in  in  5  requester id of the slot.
REQ-006 pkt_addr_in  in  36  slot address; for write beats, [5:4] is the beat index.
REQ-007 pkt_data_in  in  128  slot payload.
REQ-008 overwrite  out  1  replace the current slot with the pkt_*_out fields this cycle.
REQ-009 pkt_type_out / pkt_id_out / pkt_addr_out / pkt_data_out  out  3/5/36/128  replacement slot contents.
REQ-010 mem_req  out  1  beat access request to backing memory.
REQ-011 mem_we  out  1  1 = write, 0 = read.
REQ-012 mem_addr  out  36  the format is {line[35:6], beat[1:0], 4'b0}.
REQ-013 mem_wdata  out  128  write beat data.
REQ-014 mem_ready  in  1  the request is accepted in any cycle where mem_req & mem_ready.
REQ-015 mem_rvalid / mem_rdata  in  1/128  read data, returned in request order with any latency ≥1.

Function
REQ-016 SHALL serve one transaction at a time; the FSM states are IDLE, WR_COLLECT, WR_MEM, WR_ACK, RD_MEM, RD_RESP.
REQ-017 Consume: overwrite=1, pkt_type_out=000; this clears the slot. The block SHALL only consume in IDLE, or in WR_COLLECT for matching beats.
REQ-018 IDLE, type 011: consume, latch id and line = addr[35:6], then go to RD_MEM.
REQ-019 IDLE, type 001: consume, latch id, line and beat data, set beat_mask[addr[5:4]], then go to WR_COLLECT.
REQ-020 WR_COLLECT, type 001 with the same id and same line: consume and store the beat. A repeated beat index SHALL overwrite the earlier beat data.
REQ-021 Any non-matching packet in any state, and any packet in a busy state, SHALL pass untouched (overwrite=0).
REQ-022 beat_mask==1111 SHALL move the FSM to WR_MEM on the next cycle.
REQ-023 WR_MEM: issue 4 write beats in order 0..3, mem_we=1. Beat n SHALL be held until it is accepted with mem_ready. Go to WR_ACK after beat 3 is accepted.
REQ-024 WR_ACK: on the first cycle with pkt_type_in==000, overwrite with type 101, the latched id and addr {line,6'b0}, data 0; then go to IDLE. Non-empty slots SHALL wait.
REQ-025 RD_MEM: issue 4 read requests in order 0..3, mem_we=0.
REQ-026 RD_MEM: store each mem_rvalid beat into resp_buf[rcnt], where rcnt is a 2-bit counter. Go to RD_RESP after the 4th rvalid.
REQ-027 mem_rvalid outside RD_MEM, or beyond the 4th beat, SHALL be ignored.
REQ-028 RD_RESP: for each empty slot, overwrite with type 110, the latched id, addr {line, beat, 4'b0} and data resp_buf[beat]. Beats SHALL be sent in order 0..3, one per empty slot. Go to IDLE after beat 3.
REQ-029 When overwrite=0, the pkt_*_out fields are don't-care. When mem_req=0, mem_addr, mem_wdata and mem_we are don't-care.
REQ-030 Packets of types 101 and 110 arriving at this node SHALL never be consumed.

Reset
REQ-031 rst SHALL immediately force: state=IDLE, overwrite=0, mem_req=0, mem_we=0, pkt_type_out=000, beat_mask=0, all counters=0, all outputs 0.
REQ-032 rst mid-transaction SHALL drop all collected or buffered beats and send no ack or data. After rst deasserts, the first valid packet SHALL be served normally.

Verification
REQ-033 Read: 011 with id=5, addr=0x123456780, mem latency 3 -> four 110 packets with id 5, addrs 0x123456780/790/7A0/7B0, data equal to memory, each placed only into empty slots.
REQ-034 Write: four 001 beats with id=2 in order 3,1,0,2, then ring slots non-empty for 5 cycles -> 4 mem writes in beat order 0..3, mem_ready stall honored, then 101 with id 2 placed in the first empty slot.
REQ-035 Busy pass-through: a 011 from id 7 arriving during id 2's WR_COLLECT -> overwrite=0, packet left on ring. The same packet on a later pass in IDLE is consumed.
REQ-036 Duplicate beat: beat 1 sent twice with different data -> memory receives the second data; transaction completes after 4 distinct beats.
REQ-037 rst asserted during RD_RESP after beat 1 is sent -> no further 110 packets, outputs 0, state IDLE. A fresh read afterwards completes correctly.
REQ-038 Stray mem_rvalid in IDLE -> no state change and no ring activity.
